// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
//
// Purpose : Definitions shared by the team's 8-bit LFSR generator and the
//           lfsr_checker that validates its output stream.
//
// Contents: LFSR_W      - LFSR state / byte width (8)
//           LFSR_TAPS   - feedback tap mask, bits 4,3,2,0
//           chk_state_t - checker FSM state (HUNT / LOCKED)
//           lfsr_next() - one step of the right-shift generator
// -----------------------------------------------------------------------------
package lfsr_pkg;

  localparam int LFSR_W = 8;

  // Taps at bits 4, 3, 2 and 0 of the current state.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'h1D;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } chk_state_t;

  // Right shift by one. The parity of the tapped bits becomes the new MSB.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] r);
    return {^(r & LFSR_TAPS), r[LFSR_W-1:1]};
  endfunction

endpackage : lfsr_pkg

// File: rtl/lfsr_checker_if.sv
// -----------------------------------------------------------------------------
// lfsr_checker_if
//
// Purpose : Received LFSR byte stream, one byte per cycle when valid.
//
// Signals : rx_valid - rx_data carries one LFSR byte this cycle
//           rx_data  - received LFSR state byte
//
// Modports: master - the source of the byte stream (drives both signals)
//           slave  - the checker (samples both signals)
// -----------------------------------------------------------------------------
interface lfsr_checker_if;
  import lfsr_pkg::*;

  logic              rx_valid;
  logic [LFSR_W-1:0] rx_data;

  modport master (output rx_valid, output rx_data);
  modport slave  (input  rx_valid, input  rx_data);

endinterface : lfsr_checker_if

// File: rtl/lfsr_chk_hex.sv
// -----------------------------------------------------------------------------
// lfsr_chk_hex
//
// Purpose : Display register stage for the lfsr_checker error counter. It
//           registers the four nibbles of err_cnt, zero-extended to 16 bits,
//           for the seven-segment drivers. The outputs lag err_cnt by one
//           cycle.
//
// Build   : This module is compiled only when LFSR_CHK_HEX_EN is defined.
//
// Ports   : clk       - sole clock
//           rst       - synchronous, active-high reset (clears all nibbles)
//           err_cnt   - live error counter from the checker, ERR_W bits
//           hex0..3   - registered nibbles 0..3 of the zero-extended count
// -----------------------------------------------------------------------------
`ifdef LFSR_CHK_HEX_EN
module lfsr_chk_hex #(
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       hex0,
  output logic [3:0]       hex1,
  output logic [3:0]       hex2,
  output logic [3:0]       hex3
);

  logic [15:0] err_ext;

  assign err_ext = 16'(err_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      {hex3, hex2, hex1, hex0} <= 16'h0000;
    end else begin
      {hex3, hex2, hex1, hex0} <= err_ext;
    end
  end

endmodule : lfsr_chk_hex
`endif

// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
//
// Purpose : Locks onto the team's 8-bit LFSR byte stream and counts
//           mispredictions once locked.
//           HUNT   : every nonzero byte reseeds the prediction. LOCK_CNT
//                    consecutive correct predictions move the FSM to LOCKED.
//           LOCKED : the prediction free-runs (flywheel) and is never
//                    reseeded. Each mismatch increments the saturating
//                    err_cnt. LOSS_CNT consecutive mismatches return the
//                    FSM to HUNT.
//
// Params  : LOCK_CNT (1..15) - correct predictions needed to lock
//           LOSS_CNT (1..15) - consecutive mispredictions that drop lock
//           ERR_W    (4..16) - error counter width
//
// Ports   : clk       - sole clock, all state changes on posedge
//           rst       - synchronous, active-high reset; overrides all inputs
//           rx        - lfsr_checker_if.slave (rx_valid, rx_data)
//           err_clr   - synchronous clear of err_cnt; wins over an increment
//           locked    - FSM is in LOCKED (registered)
//           err_cnt   - saturating misprediction count while LOCKED
//           hex0..3   - nibbles of err_cnt, zero-extended to 16 bits
//
// Build   : LFSR_CHK_HEX_EN defined   -> hex0..3 are registered copies of
//                                        err_cnt nibbles (one-cycle lag)
//           LFSR_CHK_HEX_EN undefined -> hex0..3 are tied to zero
// -----------------------------------------------------------------------------
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  lfsr_checker_if.slave    rx,
  input  logic             err_clr,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       hex0,
  output logic [3:0]       hex1,
  output logic [3:0]       hex2,
  output logic [3:0]       hex3
);

  localparam logic [3:0] LOCK_THR = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_THR = 4'(LOSS_CNT);

  chk_state_t        state;
  logic [LFSR_W-1:0] pred;
  logic              pred_ok;
  logic [3:0]        match_cnt;
  logic [3:0]        miss_cnt;

  logic              hit;
  logic [3:0]        match_inc;
  logic [3:0]        miss_inc;
  logic              err_inc;
  logic              err_sat;

  assign hit       = (rx.rx_data == pred);
  assign match_inc = match_cnt + 4'd1;
  assign miss_inc  = miss_cnt + 4'd1;
  assign err_sat   = &err_cnt;

  // The state register itself drives locked, so the output is glitch-free
  // and needs no separate flop.
  assign locked = (state == ST_LOCKED);

  // Only a mismatch seen while LOCKED is an error. Mismatches during HUNT
  // are part of normal acquisition.
  always_comb begin
    // NOTE: give every always_comb output a default first. A path that
    // leaves the output unassigned would infer a latch.
    err_inc = 1'b0;
    if (rx.rx_valid && (state == ST_LOCKED) && !hit) begin
      err_inc = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Each flop
  // then samples the pre-edge value of every other flop, whatever order the
  // statements appear in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_HUNT;
      pred      <= '0;
      pred_ok   <= 1'b0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      // err_clr has priority over a simultaneous increment. The counter
      // sticks at all-ones once it saturates.
      if (err_clr) begin
        err_cnt <= '0;
      end else if (err_inc && !err_sat) begin
        err_cnt <= err_cnt + 1'b1;
      end

      if (rx.rx_valid) begin
        unique case (state)
          ST_HUNT: begin
            if (rx.rx_data == '0) begin
              // The all-zero state is the LFSR lock-up state. It is never
              // a valid seed.
              pred_ok   <= 1'b0;
              match_cnt <= '0;
            end else begin
              pred    <= lfsr_next(rx.rx_data);
              pred_ok <= 1'b1;
              if (pred_ok && hit) begin
                match_cnt <= match_inc;
                if (match_inc == LOCK_THR) begin
                  state    <= ST_LOCKED;
                  miss_cnt <= '0;
                end
              end else begin
                match_cnt <= '0;
              end
            end
          end

          ST_LOCKED: begin
            // Flywheel: the prediction advances on its own, so a corrupted
            // byte cannot drag the checker off the sequence.
            pred <= lfsr_next(pred);
            if (hit) begin
              miss_cnt <= '0;
            end else begin
              miss_cnt <= miss_inc;
              if (miss_inc == LOSS_THR) begin
                state     <= ST_HUNT;
                pred_ok   <= 1'b0;
                match_cnt <= '0;
              end
            end
          end

          default: state <= ST_HUNT;
        endcase
      end
    end
  end

`ifdef LFSR_CHK_HEX_EN
  lfsr_chk_hex #(
    .ERR_W (ERR_W)
  ) u_hex (
    .clk     (clk),
    .rst     (rst),
    .err_cnt (err_cnt),
    .hex0    (hex0),
    .hex1    (hex1),
    .hex2    (hex2),
    .hex3    (hex3)
  );
`else
  assign hex0 = 4'h0;
  assign hex1 = 4'h0;
  assign hex2 = 4'h0;
  assign hex3 = 4'h0;
`endif

endmodule : lfsr_checker

// File: tb/tb_lfsr_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_checker
//
// Two checkers see the same stimulus. dut16 uses ERR_W=16 and dut4 uses
// ERR_W=4, so err_cnt saturation can be reached in a short run. A reference
// model runs every cycle and checks both instances. A literal vector table
// covers lock, flywheel, loss of lock and zero-byte hunting. Hand-written
// sequences cover display lag, reset while locked, saturation, and a clear
// that coincides with a mismatch.
// -----------------------------------------------------------------------------
module tb_lfsr_checker;

  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 3;
`ifdef LFSR_CHK_HEX_EN
  localparam bit HEX_EN = 1'b1;
`else
  localparam bit HEX_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        err_clr;
  logic        locked16, locked4;
  logic [15:0] err16;
  logic [3:0]  err4;
  logic [3:0]  h16_0, h16_1, h16_2, h16_3;
  logic [3:0]  h4_0, h4_1, h4_2, h4_3;

  always #5 clk = ~clk;

  lfsr_checker_if rx_if ();

  lfsr_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(16)) dut16 (
    .clk(clk), .rst(rst), .rx(rx_if), .err_clr(err_clr),
    .locked(locked16), .err_cnt(err16),
    .hex0(h16_0), .hex1(h16_1), .hex2(h16_2), .hex3(h16_3)
  );

  lfsr_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(4)) dut4 (
    .clk(clk), .rst(rst), .rx(rx_if), .err_clr(err_clr),
    .locked(locked4), .err_cnt(err4),
    .hex0(h4_0), .hex1(h4_1), .hex2(h4_2), .hex3(h4_3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_hunt = 1'b1;
  logic [7:0] m_pred = 8'h00;
  bit         m_ok   = 1'b0;
  int         m_run  = 0;   // consecutive correct predictions in HUNT
  int         m_miss = 0;   // consecutive mispredictions in LOCKED
  int         m_err  = 0;   // unbounded error count since the last clear
  int         m_hex16 = 0;
  int         m_hex4  = 0;

  // One generator step. The new MSB is the parity of bits 4,3,2,0.
  function automatic logic [7:0] step(input logic [7:0] r);
    int ones;
    ones = $countones(r & 8'b0001_1101);
    return 8'((int'(r) >> 1) + (ones % 2) * 128);
  endfunction

  function automatic int sat(input int v, input int w);
    int top;
    top = (1 << w) - 1;
    return (v > top) ? top : v;
  endfunction

  task automatic model_step(input bit r, input bit v, input logic [7:0] d, input bit c);
    bit bump;
    bump = 1'b0;
    if (r) begin
      m_hunt = 1'b1; m_pred = 8'h00; m_ok = 1'b0;
      m_run = 0; m_miss = 0; m_err = 0; m_hex16 = 0; m_hex4 = 0;
      return;
    end
    // The display shows the count as it was before this edge.
    m_hex16 = HEX_EN ? sat(m_err, 16) : 0;
    m_hex4  = HEX_EN ? sat(m_err, 4)  : 0;
    if (v) begin
      if (m_hunt) begin
        if (d == 8'h00) begin
          m_ok = 1'b0; m_run = 0;
        end else begin
          if (m_ok && d == m_pred) m_run++;
          else m_run = 0;
          m_pred = step(d);
          m_ok = 1'b1;
          if (m_run == LOCK_CNT) begin
            m_hunt = 1'b0; m_miss = 0;
          end
        end
      end else begin
        if (d == m_pred) begin
          m_miss = 0;
        end else begin
          m_miss++;
          bump = 1'b1;
          if (m_miss == LOSS_CNT) begin
            m_hunt = 1'b1; m_ok = 1'b0; m_run = 0;
          end
        end
        m_pred = step(m_pred);
      end
    end
    if (c) m_err = 0;
    else if (bump) m_err++;
  endtask

  // Drive one cycle, clock it, then compare both instances with the model.
  task automatic tick(input bit r, input bit v, input logic [7:0] d, input bit c);
    rst = r; rx_if.rx_valid = v; rx_if.rx_data = d; err_clr = c;
    @(posedge clk);
    #1;
    model_step(r, v, d, c);
    check("locked16", 32'(locked16), 32'(!m_hunt));
    check("locked4",  32'(locked4),  32'(!m_hunt));
    check("err16",    32'(err16),    32'(sat(m_err, 16)));
    check("err4",     32'(err4),     32'(sat(m_err, 4)));
    check("hex16",    32'({h16_3, h16_2, h16_1, h16_0}), 32'(m_hex16));
    check("hex4",     32'({h4_3, h4_2, h4_1, h4_0}),     32'(m_hex4));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         r;
    bit         v;
    logic [7:0] d;
    bit         c;
    bit         exp_locked;
    int         exp_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit r, input bit v, input logic [7:0] d,
                              input bit c, input bit l, input int e);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.c = c; x.exp_locked = l; x.exp_err = e;
    return x;
  endfunction

  initial begin
    logic [7:0] d;
    bit         r, v, c;
    int         k;

    rst = 1'b1; err_clr = 1'b0; rx_if.rx_valid = 1'b0; rx_if.rx_data = 8'h00;

    // Reset, then lock on 01 80 40 20 10.
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h01, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h80, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h40, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h20, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h10, 0, 1, 0));
    // Flywheel: 88 correct, 00 replaces C4 (error), next(C4)=E2 correct.
    tbl.push_back(mk(0, 1, 8'h88, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h00, 0, 1, 1));
    tbl.push_back(mk(0, 1, 8'hE2, 0, 1, 1));
    // Three wrong bytes (expected 71 38 1C) drop lock.
    tbl.push_back(mk(0, 1, 8'h55, 0, 1, 2));
    tbl.push_back(mk(0, 1, 8'h55, 0, 1, 3));
    tbl.push_back(mk(0, 1, 8'h55, 0, 0, 4));
    // A fresh run re-locks, and the error count is kept.
    tbl.push_back(mk(0, 1, 8'h01, 0, 0, 4));
    tbl.push_back(mk(0, 1, 8'h80, 0, 0, 4));
    tbl.push_back(mk(0, 1, 8'h40, 0, 0, 4));
    tbl.push_back(mk(0, 1, 8'h20, 0, 0, 4));
    tbl.push_back(mk(0, 1, 8'h10, 0, 1, 4));
    // An idle cycle holds. A clear without valid still clears.
    tbl.push_back(mk(0, 0, 8'h33, 0, 1, 4));
    tbl.push_back(mk(0, 0, 8'h33, 1, 1, 0));
    // Reset, then a zero byte interrupts the hunt. 40 reseeds, and the
    // fourth correct prediction after it (C4) locks.
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h01, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h80, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h40, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h20, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h10, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h88, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hC4, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'hE2, 0, 1, 0));

    foreach (tbl[i]) begin
      tick(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].c);
      check($sformatf("tbl%0d_locked", i), 32'(locked16), 32'(tbl[i].exp_locked));
      check($sformatf("tbl%0d_err", i),    32'(err16),    32'(tbl[i].exp_err));
    end

    // Five isolated errors while locked. The display follows one cycle later.
    for (int i = 0; i < 5; i++) begin
      tick(0, 1, ~m_pred, 0);
      tick(0, 1, m_pred, 0);
    end
    check("err5", 32'(err16), 32'd5);
    check("locked_err5", 32'(locked16), 32'd1);
    check("hex0_lag", 32'(h16_0), HEX_EN ? 32'd5 : 32'd0);
    tick(1, 1, 8'h00, 1);
    check("rst_locked", 32'(locked16), 32'd0);
    check("rst_err", 32'(err16), 32'd0);
    check("rst_hex", 32'({h16_3, h16_2, h16_1, h16_0}), 32'd0);

    // Re-lock, then push the 4-bit counter past saturation.
    tick(0, 1, 8'h01, 0);
    tick(0, 1, 8'h80, 0);
    tick(0, 1, 8'h40, 0);
    tick(0, 1, 8'h20, 0);
    tick(0, 1, 8'h10, 0);
    for (int i = 0; i < 20; i++) begin
      tick(0, 1, ~m_pred, 0);
      tick(0, 1, m_pred, 0);
    end
    check("sat4", 32'(err4), 32'd15);
    check("nosat16", 32'(err16), 32'd20);
    tick(0, 1, ~m_pred, 0);
    check("sat4_hold", 32'(err4), 32'd15);
    check("sat_locked", 32'(locked4), 32'd1);
    tick(0, 1, ~m_pred, 1);
    check("clr_wins4", 32'(err4), 32'd0);
    check("clr_wins16", 32'(err16), 32'd0);

    // Randomized traffic: mostly correct bytes, with some corruption, zero
    // bytes, idle cycles, and rare clears and resets.
    tick(1, 0, 8'h00, 0);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 999) == 0);
      v = ($urandom_range(0, 9) < 8);
      c = ($urandom_range(0, 299) == 0);
      k = int'($urandom_range(0, 99));
      if (k < 85) begin
        if (!m_hunt || m_ok) d = m_pred;
        else d = 8'($urandom_range(1, 255));
      end else if (k < 89) begin
        d = 8'h00;
      end else begin
        d = 8'($urandom_range(0, 255));
      end
      tick(r, v, d, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_lfsr_checker
